// File: rtl/step_sequencer_if.sv
// Move-command channel: direction, step count and step period under valid/ready.
// Combinational wires only, so it adds no latency.
// The sender holds its fields stable while cmd_valid is high and cmd_ready is low.
interface step_sequencer_if #(
    parameter int CNT_W = 32,
    parameter int PER_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;

    modport master (output cmd_valid, cmd_dir, cmd_steps, cmd_period, input cmd_ready);
    modport slave  (input cmd_valid, cmd_dir, cmd_steps, cmd_period, output cmd_ready);
endinterface

// File: rtl/step_sequencer.sv
// Step/dir pulse scheduler for the microstepper, with abort and position tracking.
// First step rises 1 cycle after accept, or 1 + dir_setup cycles after accept; edges are per cycles apart.
// cmd_ready is high only in IDLE, so a command waits until the current move has finished.
module step_sequencer #(
    parameter int CNT_W = 32,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    step_sequencer_if.slave  cmd,
    input  logic [7:0]       config_pulse_width,
    input  logic [7:0]       config_dir_setup,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_remaining,
    output logic [CNT_W-1:0] position
);
    // Timer must hold pw + 1 (up to 256) even for narrow period widths
    localparam int TW = (PER_W > 9) ? PER_W : 9;
    localparam logic [TW-1:0]    T_ONE = TW'(1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    state_t           state_q, state_n;
    logic [TW-1:0]    tmr_q, tmr_n;
    logic [7:0]       pw_q;
    logic [TW-1:0]    per_q;
    logic             dir_q, step_q, done_q, abort_pend_q;
    logic [CNT_W-1:0] srem_q, pos_q;

    logic             accept, zero_len, need_setup, tmr_done, abort_hit;
    logic             step_n, done_n, enter_high, dir_next;
    logic [7:0]       pw_in;
    logic [TW-1:0]    pw_ext, per_in;

    assign accept     = cmd.cmd_valid && (state_q == S_IDLE);
    assign zero_len   = (cmd.cmd_steps == '0);
    assign need_setup = (cmd.cmd_dir != dir_q) && (config_dir_setup != 8'd0);
    assign tmr_done   = (tmr_q == '0);
    assign abort_hit  = abort || abort_pend_q;
    assign pw_in      = (config_pulse_width == 8'd0) ? 8'd1 : config_pulse_width;
    assign pw_ext     = TW'(pw_in);
    assign per_in     = (TW'(cmd.cmd_period) > pw_ext) ? TW'(cmd.cmd_period) : (pw_ext + T_ONE);
    assign dir_next   = accept ? cmd.cmd_dir : dir_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (accept && !zero_len) state_n = need_setup ? S_SETUP : S_HIGH;
            S_SETUP: if (abort) state_n = S_IDLE;
                     else if (tmr_done) state_n = S_HIGH;
            // An abort seen during the high time only takes effect once pw has elapsed
            S_HIGH:  if (tmr_done) state_n = abort_hit ? S_IDLE : S_LOW;
            S_LOW:   if (abort) state_n = S_IDLE;
                     else if (tmr_done) state_n = (srem_q != '0) ? S_HIGH : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        step_n        = (state_n == S_HIGH);
        enter_high    = (state_n == S_HIGH) && (state_q != S_HIGH);
        done_n        = ((state_q != S_IDLE) && (state_n == S_IDLE)) || (accept && zero_len);
    end

    always_comb begin
        tmr_n = tmr_q;
        if (state_n != state_q) begin
            case (state_n)
                S_SETUP: tmr_n = TW'(config_dir_setup) - T_ONE;
                S_HIGH:  tmr_n = (accept ? pw_ext : TW'(pw_q)) - T_ONE;
                S_LOW:   tmr_n = per_q - TW'(pw_q) - T_ONE;
                default: tmr_n = '0;
            endcase
        end else if (!tmr_done) begin
            tmr_n = tmr_q - T_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmr_q        <= '0;
            pw_q         <= 8'd1;
            per_q        <= TW'(2);
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            srem_q       <= '0;
            pos_q        <= '0;
        end else begin
            tmr_q        <= tmr_n;
            step_q       <= step_n;
            done_q       <= done_n;
            abort_pend_q <= (state_q == S_HIGH && state_n == S_HIGH) ? (abort_pend_q | abort) : 1'b0;
            if (accept) begin
                dir_q <= cmd.cmd_dir;
                pw_q  <= pw_in;
                per_q <= per_in;
            end
            if (accept)          srem_q <= enter_high ? (cmd.cmd_steps - C_ONE) : cmd.cmd_steps;
            else if (enter_high) srem_q <= srem_q - C_ONE;
            if (enter_high)      pos_q  <= dir_next ? (pos_q + C_ONE) : (pos_q - C_ONE);
        end
    end

    assign step            = step_q;
    assign dir             = dir_q;
    assign done            = done_q;
    assign steps_remaining = srem_q;
    assign position        = pos_q;
endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed and random moves checked against a timeline model
// that derives every pulse edge, done cycle and position from accept time, pw, per and setup.
module tb_step_sequencer;
    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  config_pulse_width, config_dir_setup;
    logic        abort;
    logic        step, dir, busy, done;
    logic [31:0] steps_remaining, position;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pos = '0;
    bit          m_dir = 1'b0;

    step_sequencer_if #(.CNT_W(32), .PER_W(16)) cmd_if ();

    step_sequencer #(.CNT_W(32), .PER_W(16)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .cmd                (cmd_if),
        .config_pulse_width (config_pulse_width),
        .config_dir_setup   (config_dir_setup),
        .abort              (abort),
        .step               (step),
        .dir                (dir),
        .busy               (busy),
        .done               (done),
        .steps_remaining    (steps_remaining),
        .position           (position)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // ta: cycle after accept in which abort is held for one cycle (-1 = none)
    // ab0: abort asserted together with cmd_valid in the accept cycle
    task automatic run_cmd(input bit d, input int n, input int period, input int pwc,
                           input int setup, input int ta, input bit ab0);
        int pw, per, r0, e, taken, k, ph, rises;
        bit exp_step;
        logic [31:0] exp_pos;
        pw  = (pwc == 0) ? 1 : pwc;
        per = (period > pw) ? period : pw + 1;
        r0  = 1 + ((d != m_dir && setup != 0) ? setup : 0);
        if (n == 0) begin
            e = 1; taken = 0;
        end else begin
            e = r0 + n * per; taken = n;
            if (ta >= 1 && ta < e) begin
                if (ta < r0) begin
                    e = ta + 1; taken = 0;
                end else begin
                    k  = (ta - r0) / per;
                    ph = (ta - r0) % per;
                    e  = (ph < pw) ? (r0 + k * per + pw) : (ta + 1);
                    taken = k + 1;
                end
            end
        end

        @(posedge clk); #1;
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_dir     = d;
        cmd_if.cmd_steps   = n;
        cmd_if.cmd_period  = period[15:0];
        config_pulse_width = pwc[7:0];
        config_dir_setup   = setup[7:0];
        abort              = ab0;
        @(negedge clk);
        chk("ready_at_accept", cmd_if.cmd_ready, 1'b1);

        for (int t = 1; t <= e; t++) begin
            @(posedge clk); #1;
            if (t == 1) begin
                cmd_if.cmd_valid   = 1'b0;
                cmd_if.cmd_dir     = 1'($urandom);
                cmd_if.cmd_steps   = $urandom;
                cmd_if.cmd_period  = 16'($urandom);
                config_pulse_width = 8'($urandom);
                config_dir_setup   = 8'($urandom);
            end
            abort = (t == ta);
            @(negedge clk);
            rises = (n == 0 || t < r0) ? 0 : ((t - r0) / per + 1);
            if (rises > taken) rises = taken;
            exp_step = (n != 0) && (t >= r0) && (t < e) &&
                       ((t - r0) / per < taken) && ((t - r0) % per < pw);
            exp_pos = d ? (m_pos + 32'(rises)) : (m_pos - 32'(rises));
            chk("step",  step, exp_step);
            chk("done",  done, t == e);
            chk("busy",  busy, t < e);
            chk("ready", cmd_if.cmd_ready, t >= e);
            chk("dir",   dir, d);
            chk("pos",   position, exp_pos);
            chk("srem",  steps_remaining, 32'(n - rises));
        end
        abort = 1'b0;
        m_pos = d ? (m_pos + 32'(taken)) : (m_pos - 32'(taken));
        m_dir = d;
    endtask

    initial begin
        resetn             = 1'b0;
        abort              = 1'b0;
        config_pulse_width = 8'd0;
        config_dir_setup   = 8'd0;
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_dir     = 1'b0;
        cmd_if.cmd_steps   = '0;
        cmd_if.cmd_period  = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_step",  step, 1'b0);
        chk("rst_dir",   dir, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_ready", cmd_if.cmd_ready, 1'b1);
        chk("rst_srem",  steps_remaining, 32'd0);
        chk("rst_pos",   position, 32'd0);

        run_cmd(1'b0, 3, 10, 2, 0, -1, 1'b0);           // T1
        run_cmd(1'b1, 1, 4, 1, 5, -1, 1'b0);            // T2: dir 0 -> 1 with setup
        run_cmd(1'b1, 0, 7, 2, 3, -1, 1'b0);            // T3: zero-length
        run_cmd(1'b1, 2, 1, 4, 0, -1, 1'b0);            // T4: period clamps to pw+1
        run_cmd(1'b1, 10, 8, 3, 0, 1 + 8, 1'b0);        // T5: abort in 1st high of pulse 2
        run_cmd(1'b0, 4, 6, 2, 3, 2, 1'b1);             // abort in setup, abort with accept
        run_cmd(1'b0, 3, 6, 2, 3, 5, 1'b0);             // abort in LOW
        run_cmd(1'b0, 0, 0, 0, 0, -1, 1'b1);            // zero-length with abort

        for (int i = 0; i < 40; i++) begin
            run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 20),
                    $urandom_range(0, 6), $urandom_range(0, 6),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1,
                    $urandom_range(0, 4) == 0);
        end

        // T6: async reset in the middle of a high pulse
        @(posedge clk); #1;
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_dir     = m_dir;
        cmd_if.cmd_steps   = 32'd5;
        cmd_if.cmd_period  = 16'd10;
        config_pulse_width = 8'd4;
        config_dir_setup   = 8'd0;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t6_step_high", step, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_step_async", step, 1'b0);
        chk("t6_pos",        position, 32'd0);
        chk("t6_srem",       steps_remaining, 32'd0);
        chk("t6_busy",       busy, 1'b0);
        chk("t6_done",       done, 1'b0);
        @(posedge clk); #1 resetn = 1'b1;
        m_pos = '0;
        m_dir = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_ready", cmd_if.cmd_ready, 1'b1);
            chk("t6_nodone", done, 1'b0);
            chk("t6_nostep", step, 1'b0);
        end
        run_cmd(1'b0, 2, 5, 2, 0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
